ahb_lite_slave_bridge: RTL and testbench
========================================

# ahb_lite_slave_bridge

Parametrised AHB-lite slave that converts pipelined AHB transfers into a single request/acknowledge conduit toward a register bank or memory. It sits between the AHB interconnect and the block's local storage. It generalises the earlier adapter in four ways: configurable data width, byte strobes, true address/data phase pipelining, and a proper two-cycle ERROR response. A compile-time optional watchdog aborts stalled conduit accesses.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; 32 or 64.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 255, wait-state limit before forced ERROR; 1..65535; used only with the watchdog.

Ports (one clock; reset is synchronous and active-low):
- hclk  in  1  clock, all logic on rising edge
- hresetn  in  1  synchronous active-low reset
- hsel  in  1  slave select
- haddr  in  ADDR_WIDTH  address-phase address
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hwrite  in  1  direction
- hsize  in  3  transfer size
- hburst  in  3  burst type, informational only
- hready  in  1  bus-wide ready
- hwdata  in  DATA_WIDTH  write data, valid in data phase
- hrdata  out  DATA_WIDTH  registered read data
- hreadyout  out  1  slave ready
- hresp  out  1  0 OKAY, 1 ERROR
- con_req  out  1  access request, held until con_ack
- con_write  out  1  1 write, 0 read
- con_addr  out  ADDR_WIDTH  captured address
- con_wdata  out  DATA_WIDTH  write data, registered
- con_wstrb  out  DATA_WIDTH/8  byte-lane enables
- con_seq  out  1  access was a SEQ beat
- con_rdata  in  DATA_WIDTH  read data, valid with con_ack
- con_ack  in  1  access complete
- con_slverr  in  1  access failed, valid with con_ack

## Operation
- Transfer accept: hsel && hready && htrans[1] at a rising edge captures haddr, hwrite, hsize, and SEQ flag. IDLE/BUSY, or hsel low, captures nothing; the next data phase is zero-wait OKAY.
- Strobe: little-endian. Covers 2^hsize bytes starting at haddr[log2(DATA_WIDTH/8)-1:0]. Computed for reads as well.
- Illegal transfer: 2^hsize > DATA_WIDTH/8, or haddr not aligned to its size. No conduit access; the response goes straight to ERR1.
- FSM states:
  - IDLE: hreadyout=1.
  - WDATA: write, latch hwdata; one cycle, hreadyout=0.
  - REQ: con_req=1, hreadyout=0.
  - RESP: hreadyout=1, hresp=0.
  - ERR1: hresp=1, hreadyout=0.
  - ERR2: hresp=1, hreadyout=1.
- Transitions:
  - Accepted legal read: IDLE/RESP/ERR2 → REQ.
  - Accepted legal write: IDLE/RESP/ERR2 → WDATA → REQ.
  - REQ with con_ack && !con_slverr → RESP. On a read, hrdata <= con_rdata.
  - REQ with con_ack && con_slverr → ERR1.
  - ERR1 → ERR2.
  - RESP or ERR2 → next accepted state, else IDLE.
- Pipelining: a new address phase is accepted only in IDLE, RESP, or ERR2, i.e. when hreadyout=1.
- con_req rises the cycle after entering REQ conditions. It stays high with stable con_addr, con_write, con_wstrb, and con_wdata until the cycle con_ack=1, and drops the following cycle. con_ack outside REQ is ignored.
- hrdata holds its last read value and updates only on a successful read ack.
- hburst is not decoded. Address sequencing for bursts comes from the master on each beat.

## Timing
- Reset values: hrdata=0, hreadyout=1, hresp=0, con_req=0, con_write=0, con_addr=0, con_wdata=0, con_wstrb=0, con_seq=0, state IDLE.
- Reset asserted mid-access drops con_req on the next edge. A later con_ack is ignored.
- Read with con_ack in the first REQ cycle: the data phase lasts 2 cycles (1 wait state), and hrdata is valid with hreadyout=1.
- Write, zero-latency ack: 3 cycles (WDATA, REQ, RESP).
- Each extra cycle without con_ack adds one wait state.
- ERROR response is always exactly 2 cycles: ERR1 has hreadyout=0, ERR2 has hreadyout=1.
- A master dropping to IDLE during ERR1 has its following address phase sampled normally in ERR2.

## Configuration
- AHB_BRIDGE_TIMEOUT_EN defined:
  - A 16-bit counter runs while in REQ.
  - When it reaches TIMEOUT_CYCLES without con_ack, con_req drops and the FSM enters ERR1.
  - A con_ack in that same cycle wins, giving a normal completion.
  - A late con_ack after the abort is ignored.
- AHB_BRIDGE_TIMEOUT_EN undefined: no counter; REQ waits indefinitely.

## Structure
- Package ahb_bridge_pkg holds:
  - htrans_t (IDLE, BUSY, NONSEQ, SEQ)
  - hsize encodings
  - state enum bridge_state_t
  - HRESP_OKAY/HRESP_ERROR constants
- Sub-module ahb_bridge_strobe_gen (combinational, parametrised on DATA_WIDTH) produces con_wstrb and the legal/illegal flag from hsize and the low address bits.

## Test plan
- DATA_WIDTH=32, word read at 0x10, con_ack in first REQ cycle with con_rdata=0xCAFEF00D → con_addr=0x10, con_wstrb=4'hF, one wait state, hrdata=0xCAFEF00D, hresp=0.
- Halfword write at 0x22, hwdata=0x1234_5678 → con_wstrb=4'b1100, con_wdata=0x12345678, 3-cycle data phase, OKAY.
- 4-beat INCR read 0x0/0x4/0x8/0xC with back-to-back SEQ → con_seq=0,1,1,1; each address accepted in the prior RESP cycle; 4 reads issued in order.
- Word read at 0x02 (misaligned) → no con_req; hresp=1 for 2 cycles with hreadyout 0 then 1.
- Write with con_ack and con_slverr=1 → ERR1 then ERR2; the following NONSEQ read is accepted in ERR2.
- AHB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no con_ack → con_req high exactly 8 cycles, then ERROR; con_ack injected 2 cycles later is ignored.

Source files
------------

// File: rtl/ahb_bridge_pkg.sv
// ahb_bridge_pkg: shared types and encodings for the AHB-lite slave bridge
//   htrans_t       AHB transfer types
//   HSIZE_*        transfer size encodings
//   bridge_state_t bridge FSM states (ST_* constants give the raw encodings)
//   HRESP_*        response encodings
package ahb_bridge_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;
  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WDATA = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_ERR1  = 3'd4;
  localparam logic [2:0] ST_ERR2  = 3'd5;
  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_WDATA = ST_WDATA,
    S_REQ   = ST_REQ,
    S_RESP  = ST_RESP,
    S_ERR1  = ST_ERR1,
    S_ERR2  = ST_ERR2
  } bridge_state_t;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb_lite_slave_bridge_if.sv
// ahb_lite_slave_bridge_if: AHB-lite slave bus plus request/ack conduit
//   AHB side : hsel, haddr, htrans, hwrite, hsize, hburst, hready, hwdata -> bridge
//              hrdata, hreadyout, hresp <- bridge
//   conduit  : con_req, con_write, con_addr, con_wdata, con_wstrb, con_seq <- bridge
//              con_rdata, con_ack, con_slverr -> bridge
//   modports : slave (the bridge), master (bus master and conduit responder)
interface ahb_lite_slave_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();
  logic                      hsel;
  logic [ADDR_WIDTH-1:0]     haddr;
  ahb_bridge_pkg::htrans_t   htrans;
  logic                      hwrite;
  logic [2:0]                hsize;
  logic [2:0]                hburst;
  logic                      hready;
  logic [DATA_WIDTH-1:0]     hwdata;
  logic [DATA_WIDTH-1:0]     hrdata;
  logic                      hreadyout;
  logic                      hresp;
  logic                      con_req;
  logic                      con_write;
  logic [ADDR_WIDTH-1:0]     con_addr;
  logic [DATA_WIDTH-1:0]     con_wdata;
  logic [DATA_WIDTH/8-1:0]   con_wstrb;
  logic                      con_seq;
  logic [DATA_WIDTH-1:0]     con_rdata;
  logic                      con_ack;
  logic                      con_slverr;
  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hready, hwdata,
    input  con_rdata, con_ack, con_slverr,
    output hrdata, hreadyout, hresp,
    output con_req, con_write, con_addr, con_wdata, con_wstrb, con_seq
  );
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hready, hwdata,
    output con_rdata, con_ack, con_slverr,
    input  hrdata, hreadyout, hresp,
    input  con_req, con_write, con_addr, con_wdata, con_wstrb, con_seq
  );
endinterface

// File: rtl/ahb_bridge_strobe_gen.sv
// ahb_bridge_strobe_gen: little-endian byte-lane strobes and legality check
//   hsize   transfer size (2^hsize bytes)
//   addr_lo address bits selecting the byte lane
//   wstrb   byte-lane enables, all zero for an illegal transfer
//   legal   transfer fits the bus and is size-aligned
module ahb_bridge_strobe_gen #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                      hsize,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] addr_lo,
  output logic [DATA_WIDTH/8-1:0]         wstrb,
  output logic                            legal
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  logic [7:0]    nbytes;
  logic [NB-1:0] mask;
  assign nbytes = 8'd1 << hsize;
  // a full-width transfer shifts the one out of range, so 0 - 1 yields all lanes
  assign mask = (NB'(1) << nbytes) - NB'(1);
  // for a full-width size the low bits of nbytes are zero, so every addr_lo bit counts
  assign legal = hsize <= 3'(LB) && ~|(addr_lo & (nbytes[LB-1:0] - LB'(1)));
  assign wstrb = legal ? mask << addr_lo : '0;
endmodule

// File: rtl/ahb_lite_slave_bridge.sv
// ahb_lite_slave_bridge: AHB-lite slave turning pipelined transfers into a request/ack conduit
//   hclk    clock, rising edge
//   hresetn synchronous active-low reset
//   bus     ahb_lite_slave_bridge_if.slave: AHB slave port and conduit master port
// Optional watchdog: define AHB_BRIDGE_TIMEOUT_EN to abort a REQ after TIMEOUT_CYCLES cycles
// without con_ack, answering with ERROR.
module ahb_lite_slave_bridge
  import ahb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                    hclk,
  input logic                    hresetn,
  ahb_lite_slave_bridge_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  bridge_state_t state, nxt, acc_nxt;
  logic          legal, rdy, accept, timeout, unused_hburst;
  logic [NB-1:0] strb;
  ahb_bridge_strobe_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strobe (
    .hsize   (bus.hsize),
    .addr_lo (bus.haddr[LB-1:0]),
    .wstrb   (strb),
    .legal   (legal)
  );
  assign unused_hburst = ^bus.hburst;
  assign rdy = state == S_IDLE || state == S_RESP || state == S_ERR2;
  // address phases are only sampled while this slave is not stalling the bus
  assign accept = rdy && bus.hsel && bus.hready && bus.htrans[1];
  assign acc_nxt = !legal ? S_ERR1 : bus.hwrite ? S_WDATA : S_REQ;
  assign bus.hreadyout = rdy;
  assign bus.hresp = state == S_ERR1 || state == S_ERR2 ? HRESP_ERROR : HRESP_OKAY;
`ifdef AHB_BRIDGE_TIMEOUT_EN
  logic [15:0] tcnt;
  always_ff @(posedge hclk)
    tcnt <= !hresetn || state != S_REQ ? '0 : tcnt + 16'd1;
  // fires in the last allowed REQ cycle so con_req stays up exactly TIMEOUT_CYCLES cycles
  assign timeout = tcnt == 16'(TIMEOUT_CYCLES - 1);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE, S_RESP, S_ERR2: nxt = accept ? acc_nxt : S_IDLE;
      S_WDATA:                nxt = S_REQ;
      S_REQ:                  nxt = bus.con_ack ? (bus.con_slverr ? S_ERR1 : S_RESP) : timeout ? S_ERR1 : S_REQ;
      S_ERR1:                 nxt = S_ERR2;
      default:                nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state         <= S_IDLE;
      bus.hrdata    <= '0;
      bus.con_req   <= 1'b0;
      bus.con_write <= 1'b0;
      bus.con_addr  <= '0;
      bus.con_wdata <= '0;
      bus.con_wstrb <= '0;
      bus.con_seq   <= 1'b0;
    end else begin
      state       <= nxt;
      bus.con_req <= nxt == S_REQ;
      if (accept) begin
        bus.con_addr  <= bus.haddr;
        bus.con_write <= bus.hwrite;
        bus.con_wstrb <= strb;
        bus.con_seq   <= bus.htrans == HTRANS_SEQ;
      end
      if (state == S_WDATA)
        bus.con_wdata <= bus.hwdata;
      if (state == S_REQ && bus.con_ack && !bus.con_slverr && !bus.con_write)
        bus.hrdata <= bus.con_rdata;
    end
  end
endmodule

// File: tb/tb_ahb_lite_slave_bridge.sv
// tb_ahb_lite_slave_bridge: directed scoreboard bench for ahb_lite_slave_bridge
module tb_ahb_lite_slave_bridge;
  import ahb_bridge_pkg::*;
  localparam int TO = 8;
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        seq;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } req_t;
  typedef struct {
    logic        err;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } rsp_t;
  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  int          total = 0;
  int          bad = 0;
  req_t        req_q[$];
  rsp_t        rsp_q[$];
  req_t        cur;
  int          rcnt = 0;
  int          last_len = 0;
  logic        force_ack = 1'b0;
  logic [31:0] last_rd = '0;
  ahb_lite_slave_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
  ahb_lite_slave_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );
  assign bus.hready = bus.hreadyout;
  always #5 hclk = ~hclk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // conduit responder: pops the expected request, checks it, acks after its latency
  always @(negedge hclk) begin
    if (bus.con_req) begin
      if (rcnt == 0) begin
        chk("req_expected", 64'(req_q.size() != 0), 64'd1);
        if (req_q.size() != 0) cur = req_q.pop_front();
        chk("con_addr", bus.con_addr, cur.addr);
        chk("con_write", bus.con_write, cur.wr);
        chk("con_wstrb", bus.con_wstrb, cur.strb);
        chk("con_seq", bus.con_seq, cur.seq);
        if (cur.wr) chk("con_wdata", bus.con_wdata, cur.wdata);
      end else begin
        chk("con_addr_hold", bus.con_addr, cur.addr);
        chk("con_wstrb_hold", bus.con_wstrb, cur.strb);
      end
      bus.con_ack = cur.lat == rcnt;
      bus.con_slverr = bus.con_ack && cur.err;
      bus.con_rdata = bus.con_ack ? cur.rdata : 32'hDEAD_BEEF;
      rcnt++;
    end else begin
      if (rcnt != 0) last_len = rcnt;
      rcnt = 0;
      bus.con_ack = force_ack;
      bus.con_slverr = 1'b0;
      bus.con_rdata = 32'h5A5A_5A5A;
    end
  end
  task automatic drive(input htrans_t t, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [3:0] strb, input logic [31:0] wd, input int lat, input logic err,
                       input logic [31:0] rd);
    int   nb;
    logic ok;
    nb = 1 << sz;
    ok = nb <= 4 && (a % nb) == 0;
    bus.hsel = 1'b1;
    bus.htrans = t;
    bus.haddr = a;
    bus.hwrite = wr;
    bus.hsize = sz;
    if (ok) req_q.push_back('{a, wr, strb, wd, t == HTRANS_SEQ, lat, err, rd});
    rsp_q.push_back('{!ok || err || lat < 0, wr, wd, rd,
                      !ok ? 2 : int'(wr) + (lat < 0 ? TO : lat + 1) + ((err || lat < 0) ? 2 : 1)});
  endtask
  task automatic data_phase();
    rsp_t r;
    int   n;
    logic ph;
    r = rsp_q.pop_front();
    @(negedge hclk);
    bus.hsel = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.hwdata = r.wdata;
    n = 1;
    ph = 1'b0;
    while (bus.hreadyout !== 1'b1 && n < 100) begin
      ph = bus.hresp;
      @(negedge hclk);
      n++;
    end
    chk("data_phase_cycles", 64'(n), 64'(r.cyc));
    chk("hresp", bus.hresp, r.err);
    if (r.err) chk("err1_hresp", ph, 1'b1);
    if (!r.err && !r.wr) last_rd = r.rdata;
    chk("hrdata", bus.hrdata, last_rd);
  endtask
  initial begin
    bus.hsel = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.haddr = '0;
    bus.hwrite = 1'b0;
    bus.hsize = HSIZE_WORD;
    bus.hburst = 3'b000;
    bus.hwdata = '0;
    repeat (2) @(negedge hclk);
    chk("rst_hrdata", bus.hrdata, 0);
    chk("rst_hreadyout", bus.hreadyout, 1);
    chk("rst_hresp", bus.hresp, 0);
    chk("rst_con_req", bus.con_req, 0);
    chk("rst_con_write", bus.con_write, 0);
    chk("rst_con_addr", bus.con_addr, 0);
    chk("rst_con_wdata", bus.con_wdata, 0);
    chk("rst_con_wstrb", bus.con_wstrb, 0);
    chk("rst_con_seq", bus.con_seq, 0);
    hresetn = 1'b1;
    @(negedge hclk);
    drive(HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, 4'hF, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
    data_phase();
    @(negedge hclk);
    drive(HTRANS_NONSEQ, 32'h22, 1'b1, HSIZE_HALF, 4'b1100, 32'h1234_5678, 0, 1'b0, 32'h0);
    data_phase();
    @(negedge hclk);
    bus.hburst = 3'b011;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 32'(4 * i), 1'b0, HSIZE_WORD, 4'hF, 32'h0, 0, 1'b0, 32'h1000 + 32'(i));
      data_phase();
    end
    bus.hburst = 3'b000;
    @(negedge hclk);
    drive(HTRANS_NONSEQ, 32'h02, 1'b0, HSIZE_WORD, 4'hF, 32'h0, 0, 1'b0, 32'h0);
    data_phase();
    drive(HTRANS_NONSEQ, 32'h08, 1'b0, HSIZE_DWORD, 4'hF, 32'h0, 0, 1'b0, 32'h0);
    data_phase();
    @(negedge hclk);
    drive(HTRANS_NONSEQ, 32'h44, 1'b1, HSIZE_WORD, 4'hF, 32'hA5A5_0001, 1, 1'b1, 32'h0);
    data_phase();
    drive(HTRANS_NONSEQ, 32'h48, 1'b0, HSIZE_WORD, 4'hF, 32'h0, 2, 1'b0, 32'h600D_D00D);
    data_phase();
    drive(HTRANS_NONSEQ, 32'h13, 1'b0, HSIZE_BYTE, 4'b1000, 32'h0, 0, 1'b0, 32'h1122_3344);
    data_phase();
    drive(HTRANS_NONSEQ, 32'h01, 1'b1, HSIZE_BYTE, 4'b0010, 32'h0000_AB00, 3, 1'b0, 32'h0);
    data_phase();
    bus.hsel = 1'b1;
    bus.htrans = HTRANS_BUSY;
    @(negedge hclk);
    bus.hsel = 1'b0;
    bus.htrans = HTRANS_IDLE;
    chk("busy_hreadyout", bus.hreadyout, 1);
    chk("busy_con_req", bus.con_req, 0);
    @(negedge hclk);
    drive(HTRANS_NONSEQ, 32'h50, 1'b0, HSIZE_WORD, 4'hF, 32'h0, TO - 1, 1'b0, 32'h0000_0077);
    data_phase();
`ifdef AHB_BRIDGE_TIMEOUT_EN
    @(negedge hclk);
    drive(HTRANS_NONSEQ, 32'h40, 1'b0, HSIZE_WORD, 4'hF, 32'h0, -1, 1'b0, 32'h0);
    data_phase();
    chk("timeout_req_len", 64'(last_len), 64'(TO));
    @(negedge hclk);
    force_ack = 1'b1;
    repeat (2) @(negedge hclk);
    force_ack = 1'b0;
    chk("late_ack_con_req", bus.con_req, 0);
    chk("late_ack_hreadyout", bus.hreadyout, 1);
    chk("late_ack_hresp", bus.hresp, 0);
    chk("late_ack_hrdata", bus.hrdata, last_rd);
`endif
    @(negedge hclk);
    drive(HTRANS_NONSEQ, 32'h30, 1'b0, HSIZE_WORD, 4'hF, 32'h0, -1, 1'b0, 32'h0);
    @(negedge hclk);
    bus.hsel = 1'b0;
    bus.htrans = HTRANS_IDLE;
    chk("midrst_con_req_before", bus.con_req, 1);
    hresetn = 1'b0;
    @(negedge hclk);
    chk("midrst_con_req", bus.con_req, 0);
    chk("midrst_hreadyout", bus.hreadyout, 1);
    chk("midrst_hrdata", bus.hrdata, 0);
    hresetn = 1'b1;
    rsp_q.delete();
    last_rd = '0;
    force_ack = 1'b1;
    repeat (2) @(negedge hclk);
    force_ack = 1'b0;
    @(negedge hclk);
    chk("postrst_con_req", bus.con_req, 0);
    chk("postrst_hreadyout", bus.hreadyout, 1);
    chk("postrst_hrdata", bus.hrdata, last_rd);
    chk("req_q_drained", 64'(req_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
